// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with a classic Wishbone line-fill master.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_dm #(
    parameter int unsigned LINES          = 64,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_flush,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_error,
    output logic        o_stall,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [31:0] o_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
`ifdef ICACHE_STATS_EN
    output logic [31:0] o_hit_count,
    output logic [31:0] o_miss_count,
`endif
    input  logic        i_wb_err
);

    localparam int unsigned WW = $clog2(WORDS_PER_LINE);
    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned TW = 30 - WW - IW;
    localparam int unsigned AW = IW + WW;
    localparam int unsigned CW = (WW > 0) ? WW : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOOKUP  = 2'd1;
    localparam logic [1:0] S_FILL    = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [29:0]      addr_q, addr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             flush_pend_q, flush_pend_d;
    logic [LINES-1:0] valid_q, valid_d;

    logic [TW-1:0] tag_mem [LINES];
    logic [31:0]   data_mem [LINES*WORDS_PER_LINE];

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx;
    logic [AW-1:0] req_arr;
    logic [29:0]   line_base;
    logic [29:0]   fill_word;
    logic [AW-1:0] fill_arr;
    logic          last_word;
    logic          hit;
    logic          accept;
    logic          data_we;
    logic          tag_we;
    logic          lookup_hit;
    logic          lookup_miss;
    logic          unused_addr;

    assign unused_addr = ^i_addr[1:0];

    assign req_tag   = addr_q[29 -: TW];
    assign req_idx   = addr_q[WW +: IW];
    assign req_arr   = addr_q[AW-1:0];
    assign line_base = (addr_q >> WW) << WW;
    assign fill_word = line_base | 30'(cnt_q);
    assign fill_arr  = fill_word[AW-1:0];
    assign last_word = (cnt_q == CW'(WORDS_PER_LINE - 1));

    // A flush in the lookup cycle kills the hit so the request refetches.
    assign hit         = valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !i_flush;
    assign lookup_hit  = (state_q == S_LOOKUP) && hit;
    assign lookup_miss = (state_q == S_LOOKUP) && !hit;

    always_comb begin
        case (state_q)
            S_LOOKUP: o_stall = !hit;
            S_FILL:   o_stall = 1'b1;
            default:  o_stall = 1'b0;
        endcase
    end

    assign accept = i_req && !o_stall;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        o_valid      = 1'b0;
        o_error      = 1'b0;
        o_data       = 32'h0;
        o_wb_cyc     = 1'b0;
        o_wb_stb     = 1'b0;
        o_wb_adr     = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = i_addr[31:2];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    o_valid = 1'b1;
                    o_data  = data_mem[req_arr];
                    if (accept) begin
                        addr_d = i_addr[31:2];
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    // The line is overwritten word by word, so it must not look valid meanwhile.
                    valid_d[req_idx] = 1'b0;
                    cnt_d            = '0;
                    err_d            = 1'b0;
                    flush_pend_d     = 1'b0;
                    state_d          = S_FILL;
                end
            end
            S_FILL: begin
                o_wb_cyc = 1'b1;
                o_wb_stb = 1'b1;
                o_wb_adr = {fill_word, 2'b00};
                if (i_flush) begin
                    flush_pend_d = 1'b1;
                end
                if (i_wb_err) begin
                    err_d   = 1'b1;
                    state_d = S_RESPOND;
                end else if (i_wb_ack) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                    if (last_word) begin
                        tag_we = 1'b1;
                        if (!flush_pend_q) begin
                            valid_d[req_idx] = 1'b1;
                        end
                        state_d = S_RESPOND;
                    end
                end
            end
            default: begin
                o_valid = 1'b1;
                o_error = err_q;
                o_data  = err_q ? 32'h0 : data_mem[req_arr];
                if (accept) begin
                    addr_d  = i_addr[31:2];
                    state_d = S_LOOKUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // Flush wins over any valid set on the same edge.
        if (i_flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (data_we && !i_rst) begin
            data_mem[fill_arr] <= i_wb_dat;
        end
        if (tag_we && !i_rst) begin
            tag_mem[req_idx] <= req_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + (lookup_hit ? 32'd1 : 32'd0);
        miss_cnt_d = miss_cnt_q + (lookup_miss ? 32'd1 : 32'd0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign o_hit_count  = hit_cnt_q;
    assign o_miss_count = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = lookup_hit ^ lookup_miss;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Randomized scoreboard bench for icache_dm against a line-level cache model and
// a Wishbone memory responder with configurable wait states and error injection.
module tb_icache_dm;

    localparam int LINES = 64;
    localparam int WPL   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] o_data;
    logic        o_valid;
    logic        o_error;
    logic        o_stall;
    logic        wb_cyc;
    logic        wb_stb;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat = 32'h0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;

    always #5 clk = ~clk;

    icache_dm #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (req),
        .i_addr   (addr),
        .i_flush  (flush),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_error  (o_error),
        .o_stall  (o_stall),
        .o_wb_cyc (wb_cyc),
        .o_wb_stb (wb_stb),
        .o_wb_adr (wb_adr),
        .i_wb_dat (wb_dat),
        .i_wb_ack (wb_ack),
        .i_wb_err (wb_err)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          miss;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] wb_q[$];
    int          resp_log[$];
    int          total = 0;
    int          bad = 0;
    int          cyc_cnt = 0;
    int          term_cyc = 0;
    int          s_terms = 0;
    int          wait_mode = 1;
    bit          m_valid[LINES];
    logic [31:0] m_tag[LINES];
    bit          m_err_armed = 0;
    bit          s_err_armed = 0;
    logic [31:0] m_err_addr = 32'h0;
    logic [31:0] s_err_addr = 32'h0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp_v);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout/unexpected event want normal progress", name);
    endtask

    task automatic model_flush();
        foreach (m_valid[i]) m_valid[i] = 0;
    endtask

    task automatic model_reset();
        model_flush();
        sb_q.delete();
        wb_q.delete();
        m_err_armed = 0;
        s_err_armed = 0;
    endtask

    // A line is either resident with a tag or absent; a miss fetches the whole
    // line in order unless an armed bus error cuts it short.
    task automatic predict(input logic [31:0] a);
        int unsigned lnum = (a >> 2) / WPL;
        int unsigned idx  = lnum % LINES;
        logic [31:0] tg   = lnum / LINES;
        logic [31:0] base = lnum * WPL * 4;
        logic [31:0] wa;
        exp_t e;
        e.miss = !(m_valid[idx] && m_tag[idx] == tg);
        e.err  = 1'b0;
        e.data = mem(a);
        if (e.miss) begin
            for (int w = 0; w < WPL; w++) begin
                wa = base + 32'(w * 4);
                wb_q.push_back(wa);
                if (m_err_armed && wa == m_err_addr) begin
                    e.err = 1'b1;
                    m_err_armed = 0;
                    break;
                end
            end
            if (e.err) begin
                m_valid[idx] = 0;
                e.data = 32'h0;
            end else begin
                m_valid[idx] = 1;
                m_tag[idx]   = tg;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] a, input bit fl);
        int n = 0;
        @(negedge clk);
        req   = 1'b1;
        addr  = a;
        flush = fl;
        #1;
        while (o_stall && n < 300) begin
            n++;
            @(negedge clk);
            flush = 1'b0;
            #1;
        end
        if (o_stall) begin
            fail("issue_timeout");
        end else begin
            if (fl) model_flush();
            predict(a);
        end
        @(posedge clk);
        #1;
        req   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) fail("drain_timeout");
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        model_flush();
    endtask

    task automatic wait_fill();
        int n = 0;
        @(negedge clk);
        #1;
        while (!wb_cyc && n < 50) begin
            n++;
            @(negedge clk);
            #1;
        end
        if (!wb_cyc) fail("wait_fill_timeout");
    endtask

    task automatic arm_err(input logic [31:0] a);
        m_err_armed = 1;
        m_err_addr  = a;
        s_err_armed = 1;
        s_err_addr  = a;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h1000_0000 + ($urandom_range(0, 3) << 10) + ($urandom_range(0, 7) << 4)
               + ($urandom_range(0, 3) << 2);
    endfunction

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Wishbone memory responder.
    initial begin
        int w;
        logic [31:0] ea;
        w = 0;
        forever begin
            @(negedge clk);
            wb_ack = 1'b0;
            wb_err = 1'b0;
            wb_dat = 32'h0;
            if (wb_cyc && wb_stb && !rst) begin
                if (w > 0) begin
                    w--;
                end else begin
                    s_terms++;
                    term_cyc = cyc_cnt;
                    chk("stall_in_fill", 32'(o_stall), 32'd1);
                    if (wb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL wb_unexpected: got adr %h want no bus access", wb_adr);
                    end else begin
                        ea = wb_q.pop_front();
                        chk("wb_adr", wb_adr, ea);
                    end
                    if (s_err_armed && wb_adr == s_err_addr) begin
                        wb_err = 1'b1;
                        s_err_armed = 0;
                    end else begin
                        wb_ack = 1'b1;
                        wb_dat = mem(wb_adr);
                    end
                    w = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
                end
            end else begin
                w = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
            end
        end
    end

    // Response monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (o_valid) begin
                resp_log.push_back(cyc_cnt);
                chk("resp_cyc_low", 32'(wb_cyc), 32'd0);
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resp_unexpected: got data %h want no response", o_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_data", o_data, e.data);
                    chk("resp_err", 32'(o_error), 32'(e.err));
                    if (e.miss) chk("miss_latency", cyc_cnt, term_cyc + 1);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        int t;
        int r;
        logic [31:0] a;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_error", 32'(o_error), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_stb", 32'(wb_stb), 32'd0);
        chk("rst_adr", wb_adr, 32'h0);
        chk("rst_data", o_data, 32'h0);

        // Cold miss with one wait state per word.
        wait_mode = 1;
        t = s_terms;
        issue(32'h1000_0004, 0);
        drain();
        chk("cold_reads", 32'(s_terms - t), 32'd4);

        // Hit streaming on consecutive cycles with no bus traffic.
        t = s_terms;
        issue(32'h1000_0000, 0);
        issue(32'h1000_0004, 0);
        issue(32'h1000_0008, 0);
        issue(32'h1000_000C, 0);
        drain();
        chk("stream_no_wb", 32'(s_terms - t), 32'd0);
        chk("stream_consec",
            32'(resp_log[resp_log.size() - 1] - resp_log[resp_log.size() - 4]), 32'd3);

        // Conflict on the same index with a different tag.
        t = s_terms;
        issue(32'h1000_0400, 0);
        drain();
        issue(32'h1000_0000, 0);
        drain();
        chk("conflict_reads", 32'(s_terms - t), 32'd8);

        // Flush while idle, then flush in the middle of a fill.
        flush_pulse();
        t = s_terms;
        issue(32'h1000_0008, 0);
        drain();
        chk("flush_reads", 32'(s_terms - t), 32'd4);
        wait_mode = 2;
        issue(32'h1000_0020, 0);
        wait_fill();
        flush_pulse();
        drain();
        t = s_terms;
        issue(32'h1000_0020, 0);
        drain();
        chk("midfill_flush_reads", 32'(s_terms - t), 32'd4);

        // Request and flush together in idle must miss.
        issue(32'h1000_0040, 0);
        drain();
        t = s_terms;
        issue(32'h1000_0040, 1);
        drain();
        chk("req_flush_reads", 32'(s_terms - t), 32'd4);

        // Bus error on word 2, then a full refill of the same line.
        wait_mode = 0;
        arm_err(32'h1000_0108);
        t = s_terms;
        issue(32'h1000_0100, 0);
        drain();
        chk("err_reads", 32'(s_terms - t), 32'd3);
        t = s_terms;
        issue(32'h1000_0104, 0);
        drain();
        chk("err_refill_reads", 32'(s_terms - t), 32'd4);

        // Reset after the first ack of a fill.
        wait_mode = 2;
        t = s_terms;
        issue(32'h1000_0200, 0);
        r = 0;
        while (s_terms == t && r < 50) begin
            @(negedge clk);
            #1;
            r++;
        end
        if (s_terms == t) fail("first_ack_timeout");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("rst_fill_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_fill_valid", 32'(o_valid), 32'd0);
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        t = s_terms;
        issue(32'h1000_0200, 0);
        drain();
        chk("post_rst_reads", 32'(s_terms - t), 32'd4);

        // Random traffic.
        wait_mode = -1;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 19));
            a = rand_addr();
            if (r == 0) begin
                drain();
                issue(a, 1);
            end else if (r == 1) begin
                drain();
                flush_pulse();
            end else if (r == 2) begin
                drain();
                if (!m_err_armed) arm_err(a);
                issue(a, 0);
            end else if (r == 3) begin
                @(negedge clk);
            end else begin
                issue(a, 0);
            end
        end
        drain();
        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("wb_empty", 32'(wb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch path and the instruction Wishbone bus (classic, non-pipelined).
- Services aligned 32-bit fetch requests with 1-cycle hit latency.
- On a miss, fills a whole line with sequential single Wishbone reads, then returns the requested word.
- i_flush (FENCE.I) invalidates all lines.

Parameters:
- LINES, 64, number of cache lines; power of two, ≥2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, ≥1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_req  in  1  fetch request, sampled when o_stall=0
- i_addr  in  32  fetch byte address; bits [1:0] ignored
- i_flush  in  1  invalidate all lines (single-cycle pulse)
- o_data  out  32  fetched instruction, valid when o_valid=1
- o_valid  out  1  one-cycle response strobe
- o_error  out  1  bus error on the fill covering this response; qualifies o_valid
- o_stall  out  1  cache busy; new requests are ignored
- o_wb_cyc  out  1  Wishbone cycle
- o_wb_stb  out  1  Wishbone strobe
- o_wb_adr  out  32  Wishbone byte address, word aligned
- i_wb_dat  in  32  Wishbone read data
- i_wb_ack  in  1  Wishbone acknowledge
- i_wb_err  in  1  Wishbone error

Behaviour:
- Address split:
  - word = addr[2 +: log2(WORDS_PER_LINE)]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage: data array (LINES*WORDS_PER_LINE x 32), tag array, valid bit per line held in flops.
- Reset:
  - All valid bits cleared, state IDLE.
  - o_valid=0, o_error=0, o_stall=0, o_wb_cyc=0, o_wb_stb=0, o_wb_adr=0, o_data=0.
- States: IDLE, LOOKUP, FILL, RESPOND.
- IDLE:
  - If i_req and !o_stall: latch i_addr, go to LOOKUP.
  - If no request: stay.
- LOOKUP (cycle N+1 after request):
  - Hit (valid && tag match): o_valid=1 with the word. In the same cycle accept a new i_req (back-to-back hits give 1 fetch/cycle); otherwise go to IDLE.
  - Miss: o_stall=1, word counter=0, go to FILL.
- FILL:
  - o_wb_cyc=o_wb_stb=1; o_wb_adr={tag,index,counter,2'b00}; o_stall=1.
  - On i_wb_ack: write i_wb_dat into the data array at counter and increment counter.
  - After the last word: write tag, set valid, deassert cyc/stb, go to RESPOND.
  - Words always fill 0..WORDS_PER_LINE-1 in order (no critical-word-first).
  - Between words, cyc/stb may stay high; a new address is presented in the cycle after each ack.
- RESPOND: o_valid=1, o_data=requested word, o_stall=0, go to IDLE.
- Miss latency: 2 + sum of per-word ack waits.
- Bus error:
  - i_wb_err during FILL aborts the fill: cyc/stb drop that cycle and the line is left invalid.
  - RESPOND then asserts o_valid=1, o_error=1, o_data=0.
- o_stall:
  - High during all of FILL.
  - Low in IDLE, LOOKUP-hit and RESPOND.
  - High in the cycle the miss is detected.
- i_flush:
  - Clears every valid bit at the clock edge.
  - In LOOKUP the same cycle: treated as a miss.
  - During FILL: the fill completes and the word is returned, but valid is not set for that line.
  - Flush has priority over setting valid on the same edge.
- Simultaneous i_req and i_flush in IDLE: the request is accepted and sees the cleared valid bits, so it misses.
- Reset mid-FILL: the bus cycle is dropped immediately (cyc/stb=0 next cycle), nothing is written, state IDLE.
- o_valid is never asserted for more than one cycle per accepted request; exactly one response per accepted request.

Optional Feature:
ICACHE_STATS_EN
- Defined: adds outputs o_hit_count[31:0] and o_miss_count[31:0], both reset to 0.
  - Increment in LOOKUP on hit or miss respectively.
  - Wrap modulo 2^32.
  - A flush does not clear them.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Cold miss: reset, req 0x10000004 (LINES=64, WPL=4), ack after 1 wait each → wb reads 0x10000000,04,08,0C in order; o_valid one cycle after the last ack, o_data=mem[0x10000004]; o_stall high throughout FILL.
- Hit streaming: after the fill, reqs 0x10000000,04,08,0C on consecutive cycles → o_valid on 4 consecutive cycles with the correct words; no wb activity.
- Conflict: fill 0x10000000, then req 0x10000400 (same index, different tag) → miss and refill; a following req 0x10000000 misses again.
- Flush: after a fill, pulse i_flush, req 0x10000008 → miss with 4 wb reads. Also flush mid-FILL → data returned, then the same address misses again.
- Bus error: i_wb_err on word 2 → cyc drops, o_valid=1, o_error=1, o_data=0; re-request of the same line performs a full 4-word fill.
- Reset during FILL after 1 ack → o_wb_cyc=0 next cycle, o_valid never pulses, the subsequent req misses.
